// File: rtl/serial_bus_pkg.sv
// Shared constants and FSM state type for the serial slave-to-master read path.
package serial_bus_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int BURST_SIZE = 12;

  localparam logic [1:0] READ_CMD = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    HANDSHAKE = 3'd2,
    SHIFT     = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/slave_out_port_if.sv
// Slave-core / master-receiver signal bundle of the serial output port.
interface slave_out_port_if #(
  parameter int WORD_SIZE  = serial_bus_pkg::WORD_SIZE,
  parameter int BURST_SIZE = serial_bus_pkg::BURST_SIZE
);

  logic                  start;
  logic [BURST_SIZE-1:0] burst_num;
  logic [WORD_SIZE-1:0]  word_in;
  logic                  word_valid;
  logic                  word_ack;
  logic                  master_ready;
  logic                  slave_valid;
  logic                  tx_data;
  logic                  busy;
  logic                  tx_done;

  modport slave (
    input  start, burst_num, word_in, word_valid, master_ready,
    output word_ack, slave_valid, tx_data, busy, tx_done
  );

  modport master (
    output start, burst_num, word_in, word_valid, master_ready,
    input  word_ack, slave_valid, tx_data, busy, tx_done
  );

endinterface

// File: rtl/piso_shifter.sv
// Parallel-load shift register that shifts towards bit 0 and exposes a selected bit.
module piso_shifter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign bit_o = data_q[sel_i];

endmodule

// File: rtl/slave_out_port.sv
// Serialises a burst of words from the slave core onto tx_data, LSB first,
// with a valid/ready handshake carrying bit 0 of each word.
module slave_out_port #(
  parameter int WORD_SIZE  = serial_bus_pkg::WORD_SIZE,
  parameter int BURST_SIZE = serial_bus_pkg::BURST_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  slave_out_port_if.slave bus
);

  localparam int               BIT_W    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0] NEXT_SEL = BIT_W'(1);

  serial_bus_pkg::state_e state_q;
  logic [BURST_SIZE-1:0]  burst_q;
  logic [BURST_SIZE-1:0]  word_cnt_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic                   slave_valid_q;
  logic                   tx_data_q;
  logic                   word_ack_q;
  logic                   busy_q;
  logic                   tx_done_q;

  logic load_d;
  logic shift_d;
  logic next_bit;

  assign load_d  = (state_q == serial_bus_pkg::FETCH) && bus.word_valid;
  // The shifter always holds the next bit to send at index 1.
  assign shift_d = ((state_q == serial_bus_pkg::HANDSHAKE) && bus.master_ready) ||
                   ((state_q == serial_bus_pkg::SHIFT) && (bit_cnt_q != LAST_BIT));

  piso_shifter #(
    .WIDTH (WORD_SIZE),
    .SEL_W (BIT_W)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_d),
    .shift_i (shift_d),
    .data_i  (bus.word_in),
    .sel_i   (NEXT_SEL),
    .bit_o   (next_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= serial_bus_pkg::IDLE;
      burst_q       <= '0;
      word_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      slave_valid_q <= 1'b0;
      tx_data_q     <= 1'b0;
      word_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      word_ack_q <= 1'b0;
      tx_done_q  <= 1'b0;
      case (state_q)
        serial_bus_pkg::IDLE: begin
          if (bus.start) begin
            burst_q    <= bus.burst_num;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= serial_bus_pkg::FETCH;
          end
        end
        serial_bus_pkg::FETCH: begin
          if (bus.word_valid) begin
            word_ack_q    <= 1'b1;
            slave_valid_q <= 1'b1;
            tx_data_q     <= bus.word_in[0];
            state_q       <= serial_bus_pkg::HANDSHAKE;
          end
        end
        serial_bus_pkg::HANDSHAKE: begin
          if (bus.master_ready) begin
            slave_valid_q <= 1'b0;
            tx_data_q     <= next_bit;
            bit_cnt_q     <= BIT_W'(1);
            state_q       <= serial_bus_pkg::SHIFT;
          end
        end
        serial_bus_pkg::SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            tx_data_q <= 1'b0;
            bit_cnt_q <= '0;
            // Compare before incrementing so a full-range burst never wraps.
            if (word_cnt_q == burst_q) begin
              tx_done_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= serial_bus_pkg::DONE;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
              state_q    <= serial_bus_pkg::FETCH;
            end
          end else begin
            tx_data_q <= next_bit;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        serial_bus_pkg::DONE: begin
          state_q <= serial_bus_pkg::IDLE;
        end
        default: begin
          state_q <= serial_bus_pkg::IDLE;
        end
      endcase
    end
  end

  assign bus.word_ack    = word_ack_q;
  assign bus.slave_valid = slave_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.tx_done     = tx_done_q;

endmodule
